// File: rtl/alu_driver.sv
// alu_driver: sequences one command at a time through an external 4-bit ALU.
// Define ALU_DRIVER_ACC_EN to add the cmd_acc port and the accumulator.
module alu_driver (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
`ifdef ALU_DRIVER_ACC_EN
  input  logic       cmd_acc,
`endif
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_x,
  input  logic [3:0] cmd_y,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_s,
  output logic       rsp_c,
  output logic       rsp_zero,
  output logic       rsp_overflow,
  output logic       rsp_err,
  output logic [2:0] alu_select,
  output logic       alu_in_c,
  output logic [3:0] alu_in_x,
  output logic [3:0] alu_in_y,
  input  logic [3:0] alu_out_s,
  input  logic       alu_out_c,
  input  logic       alu_zero,
  input  logic       alu_overflow,
  output logic [7:0] op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   settle;
  logic   accept;
  logic   sample;
  logic   done;
  logic   op_ok;

`ifdef ALU_DRIVER_ACC_EN
  logic [3:0] acc;
`endif

  always_comb begin
    op_ok = 1'b0;
    unique case (1'b1)
      (alu_select == 3'd0): op_ok = 1'b1;
      (alu_select == 3'd1): op_ok = 1'b1;
      default:              op_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    sample    = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (settle) begin
          sample    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // DRIVE spans two cycles: the ALU gets a full settle cycle
  // on registered inputs before its outputs are sampled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      settle       <= 1'b0;
      alu_select   <= 3'd0;
      alu_in_c     <= 1'b0;
      alu_in_x     <= 4'd0;
      alu_in_y     <= 4'd0;
      rsp_s        <= 4'd0;
      rsp_c        <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_err      <= 1'b0;
      op_count     <= 8'd0;
    end else begin
      settle <= (state == DRIVE) && !settle;
      if (accept) begin
        alu_select <= cmd_op;
        alu_in_c   <= (cmd_op == 3'd1);
        alu_in_y   <= cmd_y;
`ifdef ALU_DRIVER_ACC_EN
        alu_in_x   <= cmd_acc ? acc : cmd_x;
`else
        alu_in_x   <= cmd_x;
`endif
      end
      if (sample) begin
        if (op_ok) begin
          rsp_s        <= alu_out_s;
          rsp_c        <= alu_out_c;
          rsp_zero     <= alu_zero;
          rsp_overflow <= alu_overflow;
          rsp_err      <= 1'b0;
        end else begin
          rsp_s        <= 4'd0;
          rsp_c        <= 1'b0;
          rsp_zero     <= 1'b0;
          rsp_overflow <= 1'b0;
          rsp_err      <= 1'b1;
        end
      end
      if (done) op_count <= op_count + 8'd1;
    end
  end

`ifdef ALU_DRIVER_ACC_EN
  always_ff @(posedge clk) begin
    if (!rst_n)    acc <= 4'd0;
    else if (done) acc <= rsp_s;
  end
`endif

endmodule

// File: tb/tb_alu_driver.sv
// tb_alu_driver: directed table plus corner sequences for alu_driver.
// Models the external 4-bit ALU (add/sub, carry, zero, signed overflow).
module tb_alu_driver;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_x;
  logic [3:0] cmd_y;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_s;
  logic       rsp_c;
  logic       rsp_zero;
  logic       rsp_overflow;
  logic       rsp_err;
  logic [2:0] alu_select;
  logic       alu_in_c;
  logic [3:0] alu_in_x;
  logic [3:0] alu_in_y;
  logic [3:0] alu_out_s;
  logic       alu_out_c;
  logic       alu_zero;
  logic       alu_overflow;
  logic [7:0] op_count;
`ifdef ALU_DRIVER_ACC_EN
  logic       cmd_acc;
`endif

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  // The ALU computes add-style results for every select, so an
  // unsupported op only reads zero if the driver masks it.
  logic [3:0] yy;
  logic [4:0] sum;
  assign yy = (alu_select == 3'd1) ? ~alu_in_y : alu_in_y;
  assign sum = {1'b0, alu_in_x} + {1'b0, yy} + {4'd0, alu_in_c};
  assign alu_out_s = sum[3:0];
  assign alu_out_c = sum[4];
  assign alu_zero = (sum[3:0] == 4'd0);
  assign alu_overflow = (alu_in_x[3] == yy[3]) && (sum[3] != alu_in_x[3]);

  alu_driver dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
`ifdef ALU_DRIVER_ACC_EN
    .cmd_acc      (cmd_acc),
`endif
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_x        (cmd_x),
    .cmd_y        (cmd_y),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_s        (rsp_s),
    .rsp_c        (rsp_c),
    .rsp_zero     (rsp_zero),
    .rsp_overflow (rsp_overflow),
    .rsp_err      (rsp_err),
    .alu_select   (alu_select),
    .alu_in_c     (alu_in_c),
    .alu_in_x     (alu_in_x),
    .alu_in_y     (alu_in_y),
    .alu_out_s    (alu_out_s),
    .alu_out_c    (alu_out_c),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .op_count     (op_count)
  );

  typedef struct {
    logic [2:0] op;
    logic [3:0] x;
    logic [3:0] y;
    logic       cin;
    logic [3:0] s;
    logic       c;
    logic       z;
    logic       v;
    logic       err;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Presents a command at a negedge; returns #1 after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [3:0] x,
                       input logic [3:0] y);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_x = x;
    cmd_y = y;
    chk("cmd_ready_idle", {7'd0, cmd_ready}, 8'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic to_resp();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    exp_count = (exp_count + 1) % 256;
  endtask

  initial begin
    vecs[0] = '{3'd0, 4'd3,  4'd4,  1'b0, 4'd7,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{3'd1, 4'd8,  4'd1,  1'b1, 4'd7,  1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{3'd1, 4'd5,  4'd5,  1'b1, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{3'd5, 4'd9,  4'd2,  1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{3'd0, 4'd15, 4'd1,  1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{3'd0, 4'd7,  4'd1,  1'b0, 4'd8,  1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{3'd1, 4'd3,  4'd5,  1'b1, 4'd14, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{3'd7, 4'd15, 4'd15, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{3'd2, 4'd0,  4'd0,  1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0;
    cmd_valid = 1'b1;
    cmd_op = 3'd1;
    cmd_x = 4'd5;
    cmd_y = 4'd6;
    rsp_ready = 1'b0;
`ifdef ALU_DRIVER_ACC_EN
    cmd_acc = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", {7'd0, cmd_ready}, 8'd1);
    chk("rst_rsp_valid", {7'd0, rsp_valid}, 8'd0);
    chk("rst_alu_x", {4'd0, alu_in_x}, 8'd0);
    chk("rst_alu_sel", {5'd0, alu_select}, 8'd0);
    chk("rst_alu_c", {7'd0, alu_in_c}, 8'd0);
    chk("rst_rsp", {rsp_s, rsp_c, rsp_zero, rsp_overflow, rsp_err}, 8'd0);
    chk("rst_count", op_count, 8'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_no_accept", {7'd0, cmd_ready}, 8'd1);

    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].op, vecs[i].x, vecs[i].y);
      chk($sformatf("v%0d_cin", i), {7'd0, alu_in_c}, {7'd0, vecs[i].cin});
      chk($sformatf("v%0d_busy", i), {7'd0, cmd_ready}, 8'd0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_early", i), {7'd0, rsp_valid}, 8'd0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), {7'd0, rsp_valid}, 8'd1);
      chk($sformatf("v%0d_s", i), {4'd0, rsp_s}, {4'd0, vecs[i].s});
      chk($sformatf("v%0d_flags", i),
          {4'd0, rsp_c, rsp_zero, rsp_overflow, rsp_err},
          {4'd0, vecs[i].c, vecs[i].z, vecs[i].v, vecs[i].err});
      handshake();
      chk($sformatf("v%0d_idle", i), {7'd0, rsp_valid}, 8'd0);
      chk($sformatf("v%0d_count", i), op_count, exp_count[7:0]);
    end

    issue(3'd0, 4'd2, 4'd3);
    to_resp();
    cmd_valid = 1'b1;
    cmd_x = 4'd9;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", {7'd0, rsp_valid}, 8'd1);
      chk("bp_ready", {7'd0, cmd_ready}, 8'd0);
      chk("bp_s", {4'd0, rsp_s}, 8'd5);
      chk("bp_x", {4'd0, alu_in_x}, 8'd2);
    end
    cmd_valid = 1'b0;
    handshake();
    chk("bp_idle", {7'd0, cmd_ready}, 8'd1);
    chk("bp_count", op_count, exp_count[7:0]);

    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("stray_ready", op_count, exp_count[7:0]);

    issue(3'd0, 4'd1, 4'd1);
    to_resp();
    chk("abort_pre", {7'd0, rsp_valid}, 8'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_count = 0;
    chk("abort_valid", {7'd0, rsp_valid}, 8'd0);
    chk("abort_ready", {7'd0, cmd_ready}, 8'd1);
    chk("abort_count", op_count, 8'd0);
    chk("abort_rsp_s", {4'd0, rsp_s}, 8'd0);

    for (int n = 0; n < 256; n++) begin
      issue(3'd0, n[3:0], 4'd0);
      to_resp();
      handshake();
      if (n == 254) chk("count_255", op_count, 8'd255);
    end
    chk("count_wrap", op_count, 8'd0);

`ifdef ALU_DRIVER_ACC_EN
    cmd_acc = 1'b0;
    issue(3'd0, 4'd3, 4'd4);
    to_resp();
    handshake();
    cmd_acc = 1'b1;
    issue(3'd0, 4'd0, 4'd2);
    cmd_acc = 1'b0;
    to_resp();
    chk("acc_s", {4'd0, rsp_s}, 8'd9);
    handshake();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
